// File: rtl/treeval_host_sequencer.sv
// Host-side initiator for the treeval controller command link: streams CONFIG,
// per-node NODE data fetched from an external table, then RUN, and collects the result.
module treeval_host_sequencer #(
  parameter int unsigned W_MSG          = 64,
  parameter int unsigned W_ADDR         = 10,
  parameter int unsigned MAX_DATA_WIDTH = 10,
  parameter int unsigned W_ACTION       = 3,
  parameter int unsigned W_REWARD       = 10,
  parameter int unsigned W_TMO          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [W_ADDR-1:0]          i_num_nodes,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_timeout,
  output logic signed [W_REWARD-1:0] o_result_exp,
  output logic [W_ACTION-1:0]        o_result_act,
  output logic                       o_tbl_rd_en,
  output logic [W_ADDR-1:0]          o_tbl_raddr,
  input  logic [MAX_DATA_WIDTH-1:0]  i_tbl_parent,
  input  logic [MAX_DATA_WIDTH-1:0]  i_tbl_action,
  input  logic [MAX_DATA_WIDTH-1:0]  i_tbl_reward,
  input  logic [MAX_DATA_WIDTH-1:0]  i_tbl_weight,
  output logic [W_MSG-1:0]           o_cmd_msg,
  output logic                       o_cmd_rdy,
  input  logic                       i_cmd_ack,
  input  logic [W_MSG-1:0]           i_res_msg,
  input  logic                       i_res_rdy,
  output logic                       o_res_ack
);

  localparam int unsigned W_NODE_PAD = W_MSG - 4 - W_ADDR - MAX_DATA_WIDTH;
  localparam int unsigned W_CFG_PAD  = W_MSG - 4 - W_ADDR;
  localparam logic [W_TMO-1:0] TMO_LAST = W_TMO'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StSendCfg, StFetch, StLatch, StSendPar, StSendAct, StSendRew, StSendWgt,
    StSendRun, StWaitRes
  } state_e;

  state_e                      r_state;
  logic [W_ADDR-1:0]           r_num;
  logic [W_ADDR-1:0]           r_idx;
  logic [W_TMO-1:0]            r_wdog;
  logic [MAX_DATA_WIDTH-1:0]   r_par, r_act, r_rew, r_wgt;
  logic                        r_busy, r_done, r_timeout, r_res_ack, r_cmd_rdy, r_tbl_rd_en;
  logic [W_ADDR-1:0]           r_tbl_raddr;
  logic [W_MSG-1:0]            r_cmd_msg;
  logic signed [W_REWARD-1:0]  r_result_exp;
  logic [W_ACTION-1:0]         r_result_act;

  logic [1:0]                  w_field;
  logic [MAX_DATA_WIDTH-1:0]   w_data;
  logic [W_MSG-1:0]            w_node_msg;
  logic [W_MSG-1:0]            w_msg;
  logic                        w_unused_res;

  // Upper result bits carry nothing for the host.
  assign w_unused_res = ^i_res_msg[W_MSG-1:W_REWARD+W_ACTION];

  // Select the node field carried by the current SEND_* state.
  always_comb begin
    w_field = 2'd0;
    w_data  = r_par;
    case (r_state)
      StSendAct: begin w_field = 2'd1; w_data = r_act; end
      StSendRew: begin w_field = 2'd2; w_data = r_rew; end
      StSendWgt: begin w_field = 2'd3; w_data = r_wgt; end
      default:   begin w_field = 2'd0; w_data = r_par; end
    endcase
  end

  assign w_node_msg = {2'd1, r_idx, w_field, {W_NODE_PAD{1'b0}}, w_data};

  // Build the message for the current send state (RUN is all zeros).
  always_comb begin
    w_msg = '0;
    case (r_state)
      StSendCfg:                                w_msg = {2'd2, 2'd0, {W_CFG_PAD{1'b0}}, r_num};
      StSendPar, StSendAct, StSendRew, StSendWgt: w_msg = w_node_msg;
      default:                                  w_msg = '0;
    endcase
  end

  // Sequencer FSM with registered outputs and per-handshake watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_num        <= '0;
      r_idx        <= '0;
      r_wdog       <= '0;
      r_par        <= '0;
      r_act        <= '0;
      r_rew        <= '0;
      r_wgt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_res_ack    <= 1'b0;
      r_cmd_rdy    <= 1'b0;
      r_tbl_rd_en  <= 1'b0;
      r_tbl_raddr  <= '0;
      r_cmd_msg    <= '0;
      r_result_exp <= '0;
      r_result_act <= '0;
    end else begin
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_res_ack   <= 1'b0;
      r_tbl_rd_en <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_num   <= i_num_nodes;
            r_idx   <= '0;
            r_wdog  <= '0;
            r_busy  <= 1'b1;
            r_state <= StSendCfg;
          end
        end
        StSendCfg, StSendPar, StSendAct, StSendRew, StSendWgt, StSendRun: begin
          if (!r_cmd_rdy) begin
            // Entering cycle doubles as the mandatory rdy-low gap between messages.
            r_cmd_rdy <= 1'b1;
            r_cmd_msg <= w_msg;
            r_wdog    <= '0;
          end else if (i_cmd_ack) begin
            r_cmd_rdy <= 1'b0;
            r_wdog    <= '0;
            case (r_state)
              StSendCfg: begin
                if (r_num == '0) begin
                  r_state <= StSendRun;
                end else begin
                  r_tbl_rd_en <= 1'b1;
                  r_tbl_raddr <= r_idx;
                  r_state     <= StFetch;
                end
              end
              StSendPar: r_state <= StSendAct;
              StSendAct: r_state <= StSendRew;
              StSendRew: r_state <= StSendWgt;
              StSendWgt: begin
                if (r_idx == r_num - W_ADDR'(1)) begin
                  r_state <= StSendRun;
                end else begin
                  r_idx       <= r_idx + W_ADDR'(1);
                  r_tbl_rd_en <= 1'b1;
                  r_tbl_raddr <= r_idx + W_ADDR'(1);
                  r_state     <= StFetch;
                end
              end
              default:   r_state <= StWaitRes;
            endcase
          end else if (r_wdog == TMO_LAST) begin
            r_cmd_rdy <= 1'b0;
            r_wdog    <= '0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= StIdle;
          end else begin
            r_wdog <= r_wdog + W_TMO'(1);
          end
        end
        StFetch: r_state <= StLatch;
        StLatch: begin
          // Table data is valid the cycle after the read strobe.
          r_par   <= i_tbl_parent;
          r_act   <= i_tbl_action;
          r_rew   <= i_tbl_reward;
          r_wgt   <= i_tbl_weight;
          r_wdog  <= '0;
          r_state <= StSendPar;
        end
        StWaitRes: begin
          if (i_res_rdy) begin
            r_result_exp <= $signed(i_res_msg[W_REWARD-1:0]);
            r_result_act <= i_res_msg[W_REWARD+W_ACTION-1:W_REWARD];
            r_res_ack    <= 1'b1;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_wdog       <= '0;
            r_state      <= StIdle;
          end else if (r_wdog == TMO_LAST) begin
            r_wdog    <= '0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= StIdle;
          end else begin
            r_wdog <= r_wdog + W_TMO'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_timeout    = r_timeout;
  assign o_result_exp = r_result_exp;
  assign o_result_act = r_result_act;
  assign o_tbl_rd_en  = r_tbl_rd_en;
  assign o_tbl_raddr  = r_tbl_raddr;
  assign o_cmd_msg    = r_cmd_msg;
  assign o_cmd_rdy    = r_cmd_rdy;
  assign o_res_ack    = r_res_ack;

endmodule
